// File: rtl/store_write_master.sv
// Core store buffer and BusMatrix write initiator: queues core stores in a small FIFO and
// issues them one at a time on the peripheral write channel, dropping writes that time out.
module store_write_master #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        CoreWriteValid,
  output logic        CoreWriteReady,
  input  logic [63:0] CoreWriteAddr,
  input  logic [63:0] CoreWriteData,
  input  logic [3:0]  CoreWriteStrb,
  output logic [63:0] WriteAddr,
  output logic [63:0] WriteData,
  output logic [3:0]  WriteStrb,
  input  logic        SlaverWriteReady,
  output logic        WriteError,
  output logic [63:0] ErrorAddr,
  output logic        Busy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
  localparam logic [PtrW:0]   CountFull   = (PtrW + 1)'(DEPTH);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StRelease} state_e;

  state_e state_q, state_d;

  logic [63:0] fifo_addr_q [DEPTH];
  logic [63:0] fifo_data_q [DEPTH];
  logic [3:0]  fifo_strb_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     waddr_q, waddr_d, wdata_q, wdata_d, err_addr_q, err_addr_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            err_q, err_d;
  logic            push, pop;
  logic [63:0]     head_addr;

  assign CoreWriteReady = (count_q != CountFull);
  assign push           = CoreWriteValid && CoreWriteReady;
  assign head_addr      = fifo_addr_q[rd_ptr_q];

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge ACLK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= CoreWriteAddr;
      fifo_data_q[wr_ptr_q] <= CoreWriteData;
      fifo_strb_q[wr_ptr_q] <= CoreWriteStrb;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    err_d      = 1'b0;
    err_addr_d = err_addr_q;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop = 1'b1;
          if (head_addr != '0) begin
            waddr_d = head_addr;
            wdata_d = fifo_data_q[rd_ptr_q];
            wstrb_d = fifo_strb_q[rd_ptr_q];
            cnt_d   = '0;
            state_d = StIssue;
          end else begin
            err_d      = 1'b1;
            err_addr_d = '0;
          end
        end
      end
      StIssue: begin
        cnt_d = cnt_q + 1'b1;
        // Ready seen in the first ISSUE cycle belongs to the previous address.
        if (cnt_q != '0 && SlaverWriteReady) begin
          state_d = StRelease;
          waddr_d = '0;
          wdata_d = '0;
          wstrb_d = '0;
        end else if (cnt_q == TimeoutLast) begin
          err_d      = 1'b1;
          err_addr_d = waddr_q;
          state_d    = StRelease;
          waddr_d    = '0;
          wdata_d    = '0;
          wstrb_d    = '0;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cnt_q      <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cnt_q      <= cnt_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign WriteAddr  = waddr_q;
  assign WriteData  = wdata_q;
  assign WriteStrb  = wstrb_q;
  assign WriteError = err_q;
  assign ErrorAddr  = err_addr_q;
  assign Busy       = (count_q != '0) || (state_q != StIdle);

endmodule
